operand_entry: RTL and testbench
================================

// Module: operand_entry
// PURPOSE
//  Input-side counterpart of the ALU display path: builds the two 5-bit two's-complement
//  operands from 5 value switches and two pushbuttons, instead of 10 raw switches.
//  Buttons are synchronised, debounced and edge-detected.
//  A 3-state FSM captures left, then right, then offers operands[9:0] = {left,right}
//  to the ALU/display stage on a valid/ready handshake.
// PARAMETERS
//  DEBOUNCE_CYCLES  50000  cycles a synchronised button level must stay stable before it is accepted (1 ms @ 50 MHz)
//  OPERAND_W        5      width of each operand; operands bus is 2*OPERAND_W
// PORTS
//  clk             in   1   single clock; every register is on its rising edge
//  rst_n           in   1   synchronous, active-low reset
//  sw              in   5   raw value switches, two's complement (-16..+15)
//  btn_enter       in   1   raw, asynchronous pushbutton; active high
//  btn_clear       in   1   raw, asynchronous pushbutton; active high
//  operands        out  10  {left[4:0], right[4:0]}
//  operands_valid  out  1   operands are complete and stable
//  operands_ready  in   1   consumer accepts this cycle
//  phase           out  2   FSM state for display feedback: 00 LEFT, 01 RIGHT, 10 HOLD
// BEHAVIOUR
//  - Reset, rst_n=0 at a clk edge, takes effect in any state, mid-debounce included:
//    - left=right=0, operands=0, operands_valid=0, phase=00.
//    - Sync flops, debounce counters and stable levels all return to 0.
//  - Button path, per button:
//    - 2-FF synchroniser.
//    - Counter clears whenever the synced level != stable level.
//    - When the counter reaches DEBOUNCE_CYCLES-1, stable takes the synced level.
//    - A 0->1 change of stable makes a 1-cycle pulse (enter_p / clear_p).
//    - Latency from raw press to pulse: 2 + DEBOUNCE_CYCLES cycles.
//    - A glitch shorter than DEBOUNCE_CYCLES produces no pulse.
//    - Holding a button produces exactly one pulse; release produces none.
//  - FSM (priority in this order):
//    - clear_p, any state: left=right=0, valid=0, -> LEFT. Clear wins over a same-cycle enter_p.
//    - LEFT,  enter_p: left<=sw, -> RIGHT.
//    - RIGHT, enter_p: right<=sw, valid<=1, -> HOLD.
//    - HOLD,  valid & operands_ready: valid<=0, -> LEFT. left/right keep their values for display.
//    - HOLD,  enter_p: ignored. operands and valid stay stable until the handshake or a clear.
//  - clear_p and ready in the same HOLD cycle: the transfer counts as done; the registers are still zeroed.
//  - operands_ready while valid=0 has no effect.
//  - No arithmetic here. sw is stored bit-exact; sign interpretation belongs to the consumer.
// CONFIGURATION
//  - OPERAND_ENTRY_LIVE_EN defined:
//    - In LEFT, operands[9:5] shows sw live (a preview).
//    - In RIGHT, operands[4:0] shows sw live.
//    - In HOLD, operands shows the latched values.
//    - operands_valid behaviour is unchanged.
//  - Not defined: operands always shows the latched registers only.
// STRUCTURE
//  - Package operand_entry_pkg:
//    - OPERAND_W
//    - state localparams ST_LEFT=2'b00, ST_RIGHT=2'b01, ST_HOLD=2'b10
//    - default DEBOUNCE_CYCLES
//  - Sub-module button_debounce (synchroniser + counter + rising-edge pulse):
//    - parameter DEBOUNCE_CYCLES
//    - ports clk, rst_n, raw, pulse
//    - instantiated twice
//  - Top level holds the FSM, the operand registers and the output mux.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//  1. Reset check:
//     - stimulus: hold rst_n=0 for 3 cycles, then release; no button activity.
//     - response: operands=10'h000, valid=0, phase=00.
//  2. Normal entry:
//     - stimulus: sw=5'b00011, press enter; sw=5'b11101, press enter; operands_ready=0.
//     - response: phase goes 00->01->10; operands=10'b00011_11101; valid=1 and held.
//     - stimulus: then pulse ready for 1 cycle.
//     - response: valid=0 on the next cycle; phase=00.
//  3. Debounce:
//     - stimulus: enter high for 3 cycles, low, then high for 10 cycles.
//     - response: exactly one enter_p, 6 cycles after the second rise.
//     - stimulus: hold enter high for 100 cycles.
//     - response: no further pulses.
//  4. Clear with simultaneous events:
//     - stimulus: in RIGHT with left=5'h0F, enter and clear debounce on the same cycle.
//     - response: phase=00, operands=0, valid=0.
//     - stimulus: in HOLD, clear_p on the same cycle as ready=1.
//     - response: exactly one transfer, then LEFT with zeros.
//  5. Ignored input and mid-operation reset:
//     - stimulus: in HOLD, press enter with sw=5'h10.
//     - response: operands unchanged.
//     - stimulus: assert rst_n=0 in HOLD.
//     - response: at the next edge valid=0, operands=0, phase=00.
//  6. With OPERAND_ENTRY_LIVE_EN:
//     - stimulus: in LEFT, toggle sw 5'h01 -> 5'h1F.
//     - response: operands[9:5] follows sw in the same cycle; valid stays 0.

Source files
------------

// File: rtl/operand_entry_pkg.sv
// Shared constants for operand_entry: operand width, FSM state encodings and
// the default debounce length (1 ms at 50 MHz).
package operand_entry_pkg;

    localparam int OPERAND_W               = 5;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

    localparam logic [1:0] ST_LEFT  = 2'b00;
    localparam logic [1:0] ST_RIGHT = 2'b01;
    localparam logic [1:0] ST_HOLD  = 2'b10;

    typedef enum logic [1:0] {
        S_LEFT  = ST_LEFT,
        S_RIGHT = ST_RIGHT,
        S_HOLD  = ST_HOLD
    } state_t;

endpackage

// File: rtl/button_debounce.sv
// One pushbutton path: 2-FF synchroniser, stability counter and a registered
// one-cycle pulse on each accepted press (0->1 of the stable level).
module button_debounce
    import operand_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    // The counter only runs while the synchronised level disagrees with the
    // accepted level, so any return to agreement restarts the stability window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            pulse  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            pulse <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
                pulse  <= sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/operand_entry.sv
// Operand entry: two debounced buttons step an FSM that latches left, then
// right, then offers {left,right}. Optional live preview: OPERAND_ENTRY_LIVE_EN.
module operand_entry
    import operand_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [OPERAND_W-1:0]   sw,
    input  logic                   btn_enter,
    input  logic                   btn_clear,
    output logic [2*OPERAND_W-1:0] operands,
    output logic                   operands_valid,
    input  logic                   operands_ready,
    output logic [1:0]             phase
);

    // Handshake: a transfer happens on a rising clk edge where operands_valid
    // and operands_ready are both 1; once valid rises, operands stay constant
    // until that transfer or a clear, and ready while valid=0 is ignored.

    logic                 enter_p;
    logic                 clear_p;
    state_t               state;
    logic [OPERAND_W-1:0] left_q;
    logic [OPERAND_W-1:0] right_q;
    logic                 valid_q;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_enter),
        .pulse (enter_p)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_clear),
        .pulse (clear_p)
    );

    // Clear outranks everything, including a same-cycle enter or handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_LEFT;
            left_q  <= '0;
            right_q <= '0;
            valid_q <= 1'b0;
        end else if (clear_p) begin
            state   <= S_LEFT;
            left_q  <= '0;
            right_q <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                S_LEFT: begin
                    if (enter_p) begin
                        left_q <= sw;
                        state  <= S_RIGHT;
                    end
                end
                S_RIGHT: begin
                    if (enter_p) begin
                        right_q <= sw;
                        valid_q <= 1'b1;
                        state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // left/right are kept after the transfer for display.
                    if (valid_q && operands_ready) begin
                        valid_q <= 1'b0;
                        state   <= S_LEFT;
                    end
                end
                default: begin
                    state   <= S_LEFT;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef OPERAND_ENTRY_LIVE_EN
    // The half currently being entered previews the switches.
    always_comb begin
        operands = {left_q, right_q};
        case (state)
            S_LEFT:  operands[2*OPERAND_W-1:OPERAND_W] = sw;
            S_RIGHT: operands[OPERAND_W-1:0]           = sw;
            default: operands = {left_q, right_q};
        endcase
    end
`else
    assign operands = {left_q, right_q};
`endif

    assign operands_valid = valid_q;
    assign phase          = state;

endmodule

// File: tb/tb_operand_entry.sv
// Self-checking bench for operand_entry with DEBOUNCE_CYCLES=4: directed
// button sequences, a transfer scoreboard and direct state checks.
module tb_operand_entry;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] sw = '0;
    logic       btn_enter = 1'b0;
    logic       btn_clear = 1'b0;
    logic [9:0] operands;
    logic       operands_valid;
    logic       operands_ready = 1'b0;
    logic [1:0] phase;

    logic [9:0] exp_q[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         n_xfer = 0;
    int         enter_pulses = 0;
    int         first_pulse;

    operand_entry #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sw             (sw),
        .btn_enter      (btn_enter),
        .btn_clear      (btn_clear),
        .operands       (operands),
        .operands_valid (operands_valid),
        .operands_ready (operands_ready),
        .phase          (phase)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // scoreboard monitor: every handshake pops one expected operand pair
    always @(negedge clk) begin
        if (rst_n && operands_valid && operands_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL xfer_unexpected: got 0x%0h expected none", operands);
            end else begin
                check("xfer_operands", 32'(operands), 32'(exp_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (dut.enter_p) enter_pulses++;
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_enter(input logic [4:0] v);
        sw = v;
        btn_enter = 1'b1;
        tick(DEB + 4);
        btn_enter = 1'b0;
        tick(DEB + 4);
    endtask

    task automatic handshake();
        operands_ready = 1'b1;
        tick(1);
        operands_ready = 1'b0;
    endtask

    function automatic logic [9:0] left_view(input logic [4:0] l, input logic [4:0] r, input logic [4:0] s);
`ifdef OPERAND_ENTRY_LIVE_EN
        return {s, r};
`else
        return {l, r};
`endif
    endfunction

    initial begin
        // 1. reset
        rst_n = 1'b0;
        tick(3);
        check("rst_valid_in_reset", 32'(operands_valid), 32'h0);
        rst_n = 1'b1;
        tick(2);
        check("rst_operands", 32'(operands), 32'(left_view(5'h00, 5'h00, 5'h00)));
        check("rst_valid", 32'(operands_valid), 32'h0);
        check("rst_phase", 32'(phase), 32'h0);

        // 2. normal entry
        press_enter(5'b00011);
        check("entry_phase_right", 32'(phase), 32'h1);
        check("entry_valid_low", 32'(operands_valid), 32'h0);
        press_enter(5'b11101);
        check("entry_phase_hold", 32'(phase), 32'h2);
        check("entry_operands", 32'(operands), 32'h07D);
        check("entry_valid", 32'(operands_valid), 32'h1);
        exp_q.push_back(10'h07D);
        tick(5);
        check("entry_valid_held", 32'(operands_valid), 32'h1);
        check("entry_operands_held", 32'(operands), 32'h07D);
        handshake();
        check("entry_valid_after_xfer", 32'(operands_valid), 32'h0);
        check("entry_phase_after_xfer", 32'(phase), 32'h0);
        check("entry_operands_kept", 32'(operands), 32'(left_view(5'b00011, 5'b11101, sw)));

        // ready with valid=0 does nothing
        operands_ready = 1'b1;
        tick(3);
        operands_ready = 1'b0;
        check("ready_idle_phase", 32'(phase), 32'h0);
        check("ready_idle_valid", 32'(operands_valid), 32'h0);

        // 3. debounce: short glitch, then a long hold
        sw = 5'h0F;
        enter_pulses = 0;
        btn_enter = 1'b1;
        tick(3);
        btn_enter = 1'b0;
        tick(6);
        check("glitch_no_pulse", 32'(enter_pulses), 32'h0);
        check("glitch_phase", 32'(phase), 32'h0);
        btn_enter = 1'b1;
        first_pulse = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (dut.enter_p && first_pulse == 0) first_pulse = i;
        end
        check("debounce_latency", 32'(first_pulse), 32'd6);
        check("debounce_phase_right", 32'(phase), 32'h1);
        tick(90);
        btn_enter = 1'b0;
        tick(DEB + 4);
        check("hold_single_pulse", 32'(enter_pulses), 32'd1);
        check("hold_phase_right", 32'(phase), 32'h1);

        // 4. clear with same-cycle enter in RIGHT (left=0F)
        sw = 5'h07;
        btn_enter = 1'b1;
        btn_clear = 1'b1;
        tick(DEB + 4);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        tick(DEB + 4);
        check("clr_enter_phase", 32'(phase), 32'h0);
        check("clr_enter_operands", 32'(operands), 32'(left_view(5'h00, 5'h00, sw)));
        check("clr_enter_valid", 32'(operands_valid), 32'h0);

        // clear pulse on the same cycle as ready in HOLD
        press_enter(5'h05);
        press_enter(5'h0A);
        check("clr_ready_pre_operands", 32'(operands), 32'h0AA);
        exp_q.push_back(10'h0AA);
        n_xfer = 0;
        btn_clear = 1'b1;
        tick(DEB + 2);
        operands_ready = 1'b1;
        tick(1);
        operands_ready = 1'b0;
        check("clr_ready_phase", 32'(phase), 32'h0);
        check("clr_ready_valid", 32'(operands_valid), 32'h0);
        check("clr_ready_operands", 32'(operands), 32'(left_view(5'h00, 5'h00, sw)));
        btn_clear = 1'b0;
        tick(DEB + 4);
        check("clr_ready_one_xfer", 32'(n_xfer), 32'd1);

        // 5. enter ignored in HOLD, then reset in HOLD
        press_enter(5'h03);
        press_enter(5'h1C);
        press_enter(5'h10);
        check("hold_ignore_operands", 32'(operands), 32'h07C);
        check("hold_ignore_valid", 32'(operands_valid), 32'h1);
        check("hold_ignore_phase", 32'(phase), 32'h2);
        rst_n = 1'b0;
        tick(1);
        check("midrst_valid", 32'(operands_valid), 32'h0);
        check("midrst_operands", 32'(operands), 32'(left_view(5'h00, 5'h00, sw)));
        check("midrst_phase", 32'(phase), 32'h0);
        rst_n = 1'b1;
        tick(2);

        // entry still works after the reset
        press_enter(5'h1F);
        press_enter(5'h01);
        exp_q.push_back(10'h3E1);
        handshake();
        check("post_rst_phase", 32'(phase), 32'h0);

`ifdef OPERAND_ENTRY_LIVE_EN
        // 6. live preview in LEFT
        sw = 5'h01;
        #1;
        check("live_left_01", 32'(operands[9:5]), 32'h01);
        sw = 5'h1F;
        #1;
        check("live_left_1f", 32'(operands[9:5]), 32'h1F);
        check("live_valid", 32'(operands_valid), 32'h0);
`endif

        tick(3);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
